// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier sequencer (mult_seq and mult_op_fifo).
package mult_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = IDLE,
    ST_LOAD    = LOAD,
    ST_RUN     = RUN,
    ST_CAPTURE = CAPTURE,
    ST_RESP    = RESP
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair FIFO: registered storage, no fall-through, count tracks 0..DEPTH.
module mult_op_fifo
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  op_pair_t wdata,
  input  logic     pop,
  output op_pair_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  op_pair_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally; count alone separates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mult_seq.sv
// Sequencer for the 32x32 shift-add multiplier: operand FIFO, load/start control, result buffer.
// Optional RUN timeout with sticky err: define MULT_SEQ_TIMEOUT_EN.
module mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_a,
  input  logic [OP_W-1:0]   req_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  output logic              mul_load,
  output logic              mul_start,
  input  logic [PROD_W-1:0] mul_prod,
  input  logic              mul_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_prod,
  output logic              busy,
  output logic              err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mult_seq: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 63) begin : g_bad_timeout
    $error("mult_seq: TIMEOUT must fit the 6-bit run counter");
  end

  state_t   state;
  op_pair_t req_pair;
  op_pair_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;
  logic     timeout_hit;

  assign req_pair  = '{a: req_a, b: req_b};
  assign req_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  // Pop only when the result buffer is free, so a new op never overwrites a pending result.
  assign pop       = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_RESP) && res_ready));

  mult_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .wdata (req_pair),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MULT_SEQ_TIMEOUT_EN
  logic [5:0] run_cnt;

  assign timeout_hit = (state == ST_RUN) && !mul_done && (run_cnt == 6'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
      err     <= 1'b0;
    end else begin
      run_cnt <= (state == ST_RUN) ? run_cnt + 6'd1 : 6'd0;
      if (timeout_hit) err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Control FSM with registered multiplier and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_load  <= 1'b0;
      mul_start <= 1'b0;
      res_valid <= 1'b0;
      res_prod  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            mul_a    <= head.a;
            mul_b    <= head.b;
            mul_load <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mul_load  <= 1'b0;
          mul_start <= 1'b1;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          if (mul_done) begin
            res_prod  <= mul_prod;
            mul_start <= 1'b0;
            state     <= ST_CAPTURE;
          end else if (timeout_hit) begin
            mul_start <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              mul_a    <= head.a;
              mul_b    <= head.b;
              mul_load <= 1'b1;
              state    <= ST_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq with a behavioural 33-cycle multiplier and product scoreboard.
module tb_mult_seq;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b, mul_a, mul_b;
  logic        mul_load, mul_start, mul_done;
  logic [63:0] mul_prod, res_prod;
  logic        res_valid, res_ready, busy, err;

  mult_seq #(.DEPTH(4), .TIMEOUT(40)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load), .mul_start(mul_start),
    .mul_prod(mul_prod), .mul_done(mul_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_prod(res_prod),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Multiplier model: done 33 cycles after start rises, held while start stays high.
  int unsigned mcnt;
  bit          no_done;
  always @(posedge clk) begin
    if (mul_load) begin
      mcnt <= 0; mul_done <= 1'b0; mul_prod <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (mul_start) begin
      if (mcnt == 32 && !no_done) begin
        mul_done <= 1'b1;
        mul_prod <= 64'(mul_a) * 64'(mul_b);
      end
      if (mcnt < 60) mcnt <= mcnt + 1;
    end else begin
      mcnt <= 0; mul_done <= 1'b0;
    end
  end

  int unsigned tests, fails;
  logic [31:0] pa[$], pb[$];
  logic [63:0] expq[$];
  int          ready_mode;
  bit          saw_full, start_during_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, score results, then drive the next request.
  task automatic cyc();
    @(negedge clk);
    case (ready_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'b0;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
    if (res_valid && res_ready) begin
      if (expq.size() == 0) check("spurious_result", 64'(res_valid), 64'(0));
      else                  check("res_prod", res_prod, expq.pop_front());
    end
    if (res_valid && mul_start) start_during_res = 1'b1;
    if (!req_ready) saw_full = 1'b1;
    if (pa.size() > 0) begin
      req_valid = 1'b1; req_a = pa[0]; req_b = pb[0];
      if (req_ready) begin
        expq.push_back(64'(pa[0]) * 64'(pb[0]));
        void'(pa.pop_front());
        void'(pb.pop_front());
      end
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while ((pa.size() > 0 || expq.size() > 0 || busy) && n < max_cyc) begin
      cyc();
      n++;
    end
    check(tag, 64'(n < max_cyc), 64'(1));
  endtask

  task automatic push_rand(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      pa.push_back($urandom);
      pb.push_back($urandom);
    end
  endtask

  initial begin
    int load_first, load_cnt, done_at, rv_at, n, runs;
    bit have_prev, unstable, saw_rv;
    logic [63:0] prev;
    tests = 0; fails = 0; ready_mode = 0; no_done = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_mul_load", 64'(mul_load), 64'(0));
    check("rst_mul_start", 64'(mul_start), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_operands", {mul_a, mul_b}, 64'(0));
    check("rst_res_prod", res_prod, 64'(0));
    reset = 1'b0;

    // 3 x 5 with timing of load pulse and result latency.
    pa.push_back(32'd3); pb.push_back(32'd5);
    load_first = -1; load_cnt = 0; done_at = -1; rv_at = -1;
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (mul_load) begin
        load_cnt++;
        if (load_first < 0) load_first = i;
        check("load_operands", {mul_a, mul_b}, {32'd3, 32'd5});
      end
      if (mul_done && done_at < 0) done_at = i;
      if (res_valid && rv_at < 0) begin
        rv_at = i;
        check("prod_3x5", res_prod, 64'h0F);
      end
      if (i > 3 && !busy) break;
    end
    check("load_cycle", 64'(load_first), 64'(2));
    check("load_width", 64'(load_cnt), 64'(1));
    check("res_latency", 64'(rv_at - done_at), 64'(2));
    drain("drain_single", 50);

    // Largest operands.
    pa.push_back(32'hFFFF_FFFF); pb.push_back(32'hFFFF_FFFF);
    drain("drain_max", 200);
    check("prod_max", res_prod, 64'hFFFF_FFFE_0000_0001);

    // Five back-to-back requests while the first runs.
    saw_full = 1'b0;
    push_rand(5);
    drain("drain_burst", 600);
    check("burst_full_seen", 64'(saw_full), 64'(1));

    // Result held off for 100 cycles.
    ready_mode = 1; saw_full = 1'b0; have_prev = 1'b0; unstable = 1'b0;
    push_rand(6);
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (res_valid) begin
        if (have_prev && res_prod !== prev) unstable = 1'b1;
        prev = res_prod; have_prev = 1'b1;
      end
    end
    check("bp_res_valid", 64'(res_valid), 64'(1));
    check("bp_stable", 64'(unstable), 64'(0));
    check("bp_fifo_full", 64'(req_ready), 64'(0));
    check("bp_pending", 64'(pa.size()), 64'(1));
    check("bp_mul_start", 64'(mul_start), 64'(0));
    ready_mode = 0;
    drain("drain_bp", 800);

    // Randomised traffic with random consumer back-pressure.
    ready_mode = 2;
    pa.push_back(32'h0); pb.push_back(32'hFFFF_FFFF);
    pa.push_back(32'h8000_0000); pb.push_back(32'h2);
    push_rand(8);
    drain("drain_rand", 3000);
    ready_mode = 0;
    check("no_start_while_res", 64'(start_during_res), 64'(0));

    // Reset ten cycles into RUN discards everything.
    push_rand(3);
    n = 0;
    while (!mul_start && n < 20) begin cyc(); n++; end
    check("run_reached", 64'(mul_start), 64'(1));
    repeat (10) cyc();
    #2 reset = 1'b1;
    #1;
    check("rst_run_mul_start", 64'(mul_start), 64'(0));
    check("rst_run_busy", 64'(busy), 64'(0));
    check("rst_run_req_ready", 64'(req_ready), 64'(1));
    pa.delete(); pb.delete(); expq.delete();
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    saw_rv = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (res_valid) saw_rv = 1'b1;
    end
    check("rst_no_res", 64'(saw_rv), 64'(0));
    check("rst_idle", 64'(busy), 64'(0));

`ifdef MULT_SEQ_TIMEOUT_EN
    // Multiplier never finishes: abort after 40 RUN cycles.
    no_done = 1'b1;
    @(negedge clk); req_valid = 1'b1; req_a = 32'd7; req_b = 32'd9;
    @(negedge clk); req_valid = 1'b0;
    runs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (err) break;
      if (mul_start) runs++;
    end
    check("to_err", 64'(err), 64'(1));
    check("to_run_cycles", 64'(runs), 64'(40));
    check("to_idle", 64'(busy), 64'(0));
    check("to_no_res", 64'(res_valid), 64'(0));
    check("to_start_low", 64'(mul_start), 64'(0));
`else
    runs = 0;
    check("err_tied_low", 64'(err + 1'(runs)), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
